// File: rtl/axis_video_timing_ctrl_pkg.sv
// Shared definitions for the AXI-Stream video timing controller: FSM state
// encoding and the clamp-to-one helper used when frame sizes are latched.
`ifndef AXIS_VIDEO_TIMING_CTRL_PKG_SV
`define AXIS_VIDEO_TIMING_CTRL_PKG_SV

// A programmed size of zero is treated as one pixel/line.
`define AVTC_CLAMP_TO_ONE(v, w) (((v) == '0) ? w'(1) : (v))

package axis_video_timing_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_HBLANK   = 2'd2,
        ST_STOPPING = 2'd3
    } state_t;

endpackage

`endif

// File: rtl/axis_video_timing_ctrl_coord.sv
// video_coord_counter: x/y pixel counter over latched frame dimensions, with
// end-of-line / end-of-frame flags. Advances only on an accepted beat.
module video_coord_counter
    import axis_video_timing_ctrl_pkg::*;
#(
    parameter int COORD_WIDTH = 12
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic                   en_i,
    input  logic [COORD_WIDTH-1:0] width_i,
    input  logic [COORD_WIDTH-1:0] height_i,
    output logic [COORD_WIDTH-1:0] x_o,
    output logic [COORD_WIDTH-1:0] y_o,
    output logic                   eol_o,
    output logic                   eof_o
);

    logic [COORD_WIDTH-1:0] w_q;
    logic [COORD_WIDTH-1:0] h_q;
    logic [COORD_WIDTH-1:0] x_q;
    logic [COORD_WIDTH-1:0] y_q;

    assign eol_o = (x_q == w_q - COORD_WIDTH'(1));
    assign eof_o = eol_o && (y_q == h_q - COORD_WIDTH'(1));
    assign x_o   = x_q;
    assign y_o   = y_q;

    // NOTE: non-blocking assignments here so that a load and an advance in the
    // same cycle both see the old sizes; the wrap of the finishing frame uses
    // the old W/H while the new ones take effect for the next frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            w_q <= COORD_WIDTH'(1);
            h_q <= COORD_WIDTH'(1);
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (load_i) begin
                w_q <= `AVTC_CLAMP_TO_ONE(width_i, COORD_WIDTH);
                h_q <= `AVTC_CLAMP_TO_ONE(height_i, COORD_WIDTH);
            end
            if (clear_i) begin
                x_q <= '0;
                y_q <= '0;
            end else if (en_i) begin
                if (eol_o) begin
                    x_q <= '0;
                    y_q <= eof_o ? '0 : y_q + COORD_WIDTH'(1);
                end else begin
                    x_q <= x_q + COORD_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/axis_video_timing_ctrl.sv
// AXI-Stream video timing controller: run/stop FSM, frame counter and AXIS
// framing. Define VIDEO_TIMING_HBLANK_EN to insert HBLANK_CYCLES idle cycles per line.
module axis_video_timing_ctrl
    import axis_video_timing_ctrl_pkg::*;
#(
    parameter int COORD_WIDTH     = 12,
    parameter int FRAME_CNT_WIDTH = 32,
    parameter int HBLANK_CYCLES   = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [COORD_WIDTH-1:0]     width_i,
    input  logic [COORD_WIDTH-1:0]     height_i,
    output logic                       m_axis_tvalid_o,
    input  logic                       m_axis_tready_i,
    output logic                       m_axis_tuser_o,
    output logic                       m_axis_tlast_o,
    output logic [COORD_WIDTH-1:0]     x_o,
    output logic [COORD_WIDTH-1:0]     y_o,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt_o,
    output logic                       busy_o
);

`ifdef VIDEO_TIMING_HBLANK_EN
    localparam bit HB_EN = (HBLANK_CYCLES != 0);
`else
    localparam bit HB_EN = 1'b0;
`endif
    localparam int              HB_W    = (HBLANK_CYCLES > 1) ? $clog2(HBLANK_CYCLES) : 1;
    localparam logic [HB_W-1:0] HB_LOAD = (HBLANK_CYCLES > 0) ? HB_W'(HBLANK_CYCLES - 1) : '0;

    state_t                     state;
    logic                       tvalid_q;
    logic                       busy_q;
    logic                       stop_pending;
    logic                       hb_after_eof;
    logic [HB_W-1:0]            hb_cnt;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_q;

    logic                       xfer;
    logic                       eol;
    logic                       eof;
    logic                       frame_end;
    logic                       stop_req;
    logic                       start_go;

    assign xfer      = tvalid_q && m_axis_tready_i;
    assign frame_end = xfer && eof;
    // A stop arriving on the frame's final beat still counts for that frame.
    assign stop_req  = stop_pending || stop_i;
    assign start_go  = (state == ST_IDLE) && start_i;

    video_coord_counter #(
        .COORD_WIDTH (COORD_WIDTH)
    ) u_coord (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clear_i  (start_go),
        .load_i   (start_go || (frame_end && !stop_req)),
        .en_i     (xfer),
        .width_i  (width_i),
        .height_i (height_i),
        .x_o      (x_o),
        .y_o      (y_o),
        .eol_o    (eol),
        .eof_o    (eof)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= ST_IDLE;
            tvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            stop_pending <= 1'b0;
            hb_after_eof <= 1'b0;
            hb_cnt       <= '0;
            frame_cnt_q  <= '0;
        end else begin
            if (frame_end) frame_cnt_q <= frame_cnt_q + FRAME_CNT_WIDTH'(1);
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state        <= stop_i ? ST_STOPPING : ST_RUN;
                        tvalid_q     <= 1'b1;
                        busy_q       <= 1'b1;
                        stop_pending <= stop_i;
                    end
                end
                ST_RUN, ST_STOPPING: begin
                    if (stop_i) begin
                        stop_pending <= 1'b1;
                        state        <= ST_STOPPING;
                    end
                    if (frame_end && stop_req) begin
                        state        <= ST_IDLE;
                        tvalid_q     <= 1'b0;
                        busy_q       <= 1'b0;
                        stop_pending <= 1'b0;
                    end else if (HB_EN && xfer && eol) begin
                        state        <= ST_HBLANK;
                        tvalid_q     <= 1'b0;
                        hb_cnt       <= HB_LOAD;
                        hb_after_eof <= eof;
                    end
                end
                ST_HBLANK: begin
                    if (stop_i) stop_pending <= 1'b1;
                    if (hb_cnt != '0) begin
                        hb_cnt <= hb_cnt - HB_W'(1);
                    end else if (hb_after_eof && stop_req) begin
                        state        <= ST_IDLE;
                        busy_q       <= 1'b0;
                        stop_pending <= 1'b0;
                    end else begin
                        state    <= stop_req ? ST_STOPPING : ST_RUN;
                        tvalid_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tuser_o  = tvalid_q && (x_o == '0) && (y_o == '0);
    assign m_axis_tlast_o  = tvalid_q && eol;
    assign frame_cnt_o     = frame_cnt_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_axis_video_timing_ctrl.sv
// Self-checking bench for axis_video_timing_ctrl (default build): frame-level
// reference model of expected beats plus a table of single-frame size vectors.
module tb_axis_video_timing_ctrl;

    logic        clk_i;
    logic        rstn_i;
    logic        start_i;
    logic        stop_i;
    logic [11:0] width_i;
    logic [11:0] height_i;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i;
    logic        m_axis_tuser_o;
    logic        m_axis_tlast_o;
    logic [11:0] x_o;
    logic [11:0] y_o;
    logic [31:0] frame_cnt_o;
    logic        busy_o;

    axis_video_timing_ctrl dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .width_i         (width_i),
        .height_i        (height_i),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .m_axis_tuser_o  (m_axis_tuser_o),
        .m_axis_tlast_o  (m_axis_tlast_o),
        .x_o             (x_o),
        .y_o             (y_o),
        .frame_cnt_o     (frame_cnt_o),
        .busy_o          (busy_o)
    );

    typedef struct {
        int x;
        int y;
        bit u;
        bit l;
        int fcnt;
    } beat_t;

    typedef struct {
        int w;
        int h;
        int beats;
        int lasts;
    } vec_t;

    int    n_checks = 0;
    int    n_errors = 0;
    int    model_fcnt = 0;
    beat_t exp_q[$];
    vec_t  tbl[6];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected beats of one frame, in raster order, with zero sizes meaning one.
    task automatic push_frame(input int w, input int h);
        int ew;
        int eh;
        ew = (w == 0) ? 1 : w;
        eh = (h == 0) ? 1 : h;
        for (int yy = 0; yy < eh; yy++)
            for (int xx = 0; xx < ew; xx++)
                exp_q.push_back('{xx, yy, (xx == 0 && yy == 0), (xx == ew - 1), model_fcnt});
        model_fcnt++;
    endtask

    task automatic start_run(input int w, input int h, input bit with_stop);
        width_i         = w[11:0];
        height_i        = h[11:0];
        start_i         = 1'b1;
        stop_i          = with_stop;
        m_axis_tready_i = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("start_latency_tvalid", m_axis_tvalid_o, 1);
        check("start_busy", busy_o, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, m_axis_tvalid_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_frame_cnt"}, frame_cnt_o, model_fcnt);
    endtask

    // Drives tready (stall_pct % stalls) and stray start pulses; compares n beats
    // against the model queue and checks outputs hold steady across stalls.
    task automatic stream(input int n, input int stall_pct, input int stop_at,
                          input int chg_at, input int chg_w);
        int          done = 0;
        int          cyc = 0;
        bit          prev_stall = 1'b0;
        logic [25:0] prev_sig = '0;
        logic [25:0] cur_sig;
        beat_t       e;
        while (done < n && cyc < n * 20 + 50) begin
            cur_sig = {x_o, y_o, m_axis_tuser_o, m_axis_tlast_o};
            check($sformatf("stream_tvalid_c%0d", cyc), m_axis_tvalid_o, 1);
            if (prev_stall) check($sformatf("stall_hold_c%0d", cyc), cur_sig, prev_sig);
            m_axis_tready_i = ($urandom_range(99) >= stall_pct);
            start_i         = $urandom_range(1);
            stop_i          = 1'b0;
            if (m_axis_tvalid_o && m_axis_tready_i) begin
                if (exp_q.size() == 0) begin
                    check("model_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d_x", done), x_o, e.x);
                    check($sformatf("beat%0d_y", done), y_o, e.y);
                    check($sformatf("beat%0d_tuser", done), m_axis_tuser_o, e.u);
                    check($sformatf("beat%0d_tlast", done), m_axis_tlast_o, e.l);
                    check($sformatf("beat%0d_frame_cnt", done), frame_cnt_o, e.fcnt);
                end
                if (done == stop_at) stop_i = 1'b1;
                if (done == chg_at) width_i = chg_w[11:0];
                done++;
            end
            prev_stall = m_axis_tvalid_o && !m_axis_tready_i;
            prev_sig   = cur_sig;
            tick();
            cyc++;
        end
        start_i = 1'b0;
        stop_i  = 1'b0;
        check("stream_beat_count", done, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beats;
        int lasts;
        int users;
        int cyc;

        tbl[0] = '{0, 0, 1, 1};
        tbl[1] = '{1, 3, 3, 3};
        tbl[2] = '{5, 1, 5, 1};
        tbl[3] = '{2, 0, 2, 1};
        tbl[4] = '{0, 2, 2, 2};
        tbl[5] = '{3, 3, 9, 3};

        rstn_i          = 1'b0;
        start_i         = 1'b0;
        stop_i          = 1'b0;
        width_i         = '0;
        height_i        = '0;
        m_axis_tready_i = 1'b0;
        #12;
        check("rst_tvalid", m_axis_tvalid_o, 0);
        check("rst_tuser", m_axis_tuser_o, 0);
        check("rst_tlast", m_axis_tlast_o, 0);
        check("rst_x", x_o, 0);
        check("rst_y", y_o, 0);
        check("rst_frame_cnt", frame_cnt_o, 0);
        check("rst_busy", busy_o, 0);
        rstn_i = 1'b1;
        tick();

        // 4x2 continuous, two frames back to back, stop requested in frame 1.
        push_frame(4, 2);
        push_frame(4, 2);
        start_run(4, 2, 1'b0);
        stream(16, 0, 9, -1, 0);
        check_idle("cont");

        // Stop pulsed at beat 2: the whole frame is still emitted.
        push_frame(4, 2);
        start_run(4, 2, 1'b0);
        stream(8, 0, 2, -1, 0);
        check_idle("stop_mid");

        // 3x2 with 50% stalls over two frames.
        push_frame(3, 2);
        push_frame(3, 2);
        start_run(3, 2, 1'b0);
        stream(12, 50, 7, -1, 0);
        check_idle("stall");

        // Width 4->2 mid-frame takes effect only at the next frame.
        push_frame(4, 2);
        push_frame(2, 2);
        start_run(4, 2, 1'b0);
        stream(12, 0, 9, 2, 2);
        check_idle("resize");

        // Zero sizes clamp to 1x1: every beat is a whole frame.
        for (int i = 0; i < 4; i++) push_frame(0, 0);
        start_run(0, 0, 1'b0);
        stream(4, 0, 3, -1, 0);
        check_idle("zero");

        // stop_i in IDLE must not be remembered by the next run.
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("idle_stop_busy", busy_o, 0);
        push_frame(2, 1);
        push_frame(2, 1);
        start_run(2, 1, 1'b0);
        stream(4, 25, 2, -1, 0);
        check_idle("idle_stop");

        // Start together with stop: exactly one frame per table vector.
        for (int i = 0; i < 6; i++) begin
            start_run(tbl[i].w, tbl[i].h, 1'b1);
            beats = 0;
            lasts = 0;
            users = 0;
            cyc   = 0;
            while (m_axis_tvalid_o && cyc < 200) begin
                m_axis_tready_i = ($urandom_range(99) >= 30);
                if (m_axis_tvalid_o && m_axis_tready_i) begin
                    beats++;
                    if (m_axis_tlast_o) lasts++;
                    if (m_axis_tuser_o) users++;
                end
                tick();
                cyc++;
            end
            model_fcnt++;
            check($sformatf("tbl%0d_beats", i), beats, tbl[i].beats);
            check($sformatf("tbl%0d_tlasts", i), lasts, tbl[i].lasts);
            check($sformatf("tbl%0d_tusers", i), users, 1);
            check_idle($sformatf("tbl%0d", i));
        end

        // Reset at beat 5 of a running frame, then a clean restart.
        push_frame(4, 2);
        start_run(4, 2, 1'b0);
        stream(5, 0, -1, -1, 0);
        exp_q.delete();
        rstn_i = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid_o, 0);
        check("mid_rst_tuser", m_axis_tuser_o, 0);
        check("mid_rst_tlast", m_axis_tlast_o, 0);
        check("mid_rst_x", x_o, 0);
        check("mid_rst_y", y_o, 0);
        check("mid_rst_frame_cnt", frame_cnt_o, 0);
        check("mid_rst_busy", busy_o, 0);
        model_fcnt = 0;
        #2;
        rstn_i = 1'b1;
        push_frame(4, 2);
        start_run(4, 2, 1'b0);
        stream(8, 0, 0, -1, 0);
        check_idle("restart");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_video_timing_ctrl.md
Name: axis_video_timing_ctrl

Overview:
- Sequences pixel/line/frame counters for the AXI-Stream video generator.
- Emits per-beat pixel coordinates plus AXIS framing (tuser = start-of-frame, tlast = end-of-line) with ready/valid handshake.
- The downstream pattern datapath turns coordinates into pixel data.
- Started and stopped by PS-side control; frame size is runtime-configurable and latched per frame.

Parameters:
- COORD_WIDTH, 12, width of x/y coordinates and size inputs (max 4095).
- FRAME_CNT_WIDTH, 32, width of completed-frame counter.
- HBLANK_CYCLES, 16, idle cycles inserted after each line (only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  pulse or level; begins streaming from IDLE.
- stop_i  in  1  pulse or level; request stop at end of current frame.
- width_i  in  COORD_WIDTH  active pixels per line.
- height_i  in  COORD_WIDTH  lines per frame.
- m_axis_tvalid_o  out  1  beat valid.
- m_axis_tready_i  in  1  downstream ready.
- m_axis_tuser_o  out  1  start of frame (x=0, y=0).
- m_axis_tlast_o  out  1  last pixel of line.
- x_o  out  COORD_WIDTH  current pixel column.
- y_o  out  COORD_WIDTH  current line.
- frame_cnt_o  out  FRAME_CNT_WIDTH  frames completed since reset.
- busy_o  out  1  high when not IDLE.

Behaviour:
- Reset (async assert, sync-released by the system): state IDLE.
  - All outputs 0: tvalid, tuser, tlast, x, y, frame_cnt, busy.
  - Latched sizes 1x1.
- States: IDLE, RUN, HBLANK (feature only), STOPPING.
- IDLE -> RUN on start_i=1:
  - Latch width_i/height_i; value 0 clamps to 1.
  - x=y=0; tvalid=1 on the next cycle; busy=1.
  - Latency from start_i to first tvalid: 1 cycle.
- RUN:
  - tvalid=1 continuously.
  - Beat transfers when tvalid & tready. On a stall, x/y/tuser/tlast hold stable.
  - On transfer: x increments. At x==W-1, x wraps to 0 and y increments.
  - At x==W-1 and y==H-1: frame completes, frame_cnt increments (wraps at 2^FRAME_CNT_WIDTH), y wraps to 0.
- Combinational flags:
  - tuser = (x==0 && y==0) while tvalid.
  - tlast = (x==W-1) while tvalid.
- Frame boundary (last beat of frame transfers):
  - If the stop request is pending -> IDLE, tvalid=0, busy=0 next cycle.
  - Else re-latch width_i/height_i for the next frame and continue RUN.
- stop_i in RUN sets a sticky stop_pending and the state shows STOPPING.
  - STOPPING behaves exactly as RUN.
  - Current frame always completes; no partial frames are emitted.
- stop_i in IDLE is ignored. start_i while not IDLE is ignored.
- Simultaneous start_i and stop_i in IDLE: start wins, stop is latched as pending. Exactly one frame is emitted, then IDLE.
- Size inputs changing mid-frame have no effect until the next frame boundary.
- Reset mid-frame: immediate return to IDLE; tvalid drops asynchronously. No completion is counted.
- W=1: tuser and tlast are both high on beat (0,0); every beat is tlast.

Optional Feature:
- Macro VIDEO_TIMING_HBLANK_EN.
- Defined: after each tlast transfer the FSM enters HBLANK.
  - Holds tvalid=0 for HBLANK_CYCLES cycles using a down-counter, then returns to RUN/STOPPING.
  - If the line was the frame's last, the frame-boundary decision (stop/re-latch) is taken at entry to HBLANK.
  - A stop request during HBLANK returns to IDLE at HBLANK exit.
  - HBLANK_CYCLES=0 behaves as undefined.
- Undefined: no HBLANK state; back-to-back lines; HBLANK_CYCLES is unused.

Decomposition:
- Shared package/header (utils include):
  - FSM state encoding constants: ST_IDLE, ST_RUN, ST_HBLANK, ST_STOPPING.
  - Clamp-to-one helper macro.
- One natural sub-module: video_coord_counter.
  - x/y counter with enable (transfer), latched W/H, wrap and end-of-line/end-of-frame flags.
  - The top keeps the FSM, stop logic, frame counter and optional blanking.

Test Plan:
- W=4,H=2, start pulse, tready=1 -> tvalid 1 cycle after start.
  - 8 beats (0,0)…(3,1); tuser on beat 0 only; tlast on beats 3 and 7.
  - Continuous; frame_cnt=1 after beat 7.
- W=3,H=2, random tready stalls (50%) -> coordinates/tuser/tlast are stable during stalls; beat sequence is identical to the no-stall run.
- W=4,H=2, stop_i pulsed at beat 2 of frame 0 -> all 8 beats emitted; busy=0 and tvalid=0 the cycle after beat 7; frame_cnt=1.
- Change width_i 4->2 mid-frame -> current frame keeps 4 pixels/line; next frame tlast every 2 beats.
- width_i=0,height_i=0, start -> every beat has tuser=tlast=1 at (0,0); frame_cnt increments per beat.
- rstn_i low at beat 5 of a running frame -> tvalid drops immediately; all outputs 0; restart begins at (0,0) with tuser. With VIDEO_TIMING_HBLANK_EN, HBLANK_CYCLES=3: exactly 3 tvalid=0 cycles after each tlast.
